// File: rtl/inference_seq_pkg.sv
// inference_seq_pkg
//   Shared types and constants for the inference sequencer.
//   state_e       : FSM state encodings (also driven out on the state port)
//   MAX_CLASS     : largest class index the display logic can show
//   INVALID_CLASS : value latched into result when the network reports junk
//   PIXELS_DEF    : default frame width (28 x 28 drawing grid)
package inference_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_LATCH   = 3'd4,
    ST_FAIL    = 3'd5
  } state_e;

  localparam int         MAX_CLASS     = 9;
  localparam logic [3:0] INVALID_CLASS = 4'hF;
  localparam int         PIXELS_DEF    = 784;

endpackage

// File: rtl/inference_sequencer_sync_edge.sv
// sync_edge
//   Two-flop synchronizer for an asynchronous level, plus a one-cycle pulse
//   on each rising edge of the synchronized level.
//   clk     : destination clock
//   reset   : asynchronous, active-high
//   async_i : level from another clock domain / a pushbutton
//   level_o : synchronized level (two flops behind async_i)
//   rise_o  : high for one cycle when level_o goes 0 -> 1
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer
//   Runs one neural-network inference per request: freezes the pixel frame,
//   stretches start for the slow network clock, waits for done with a
//   timeout and latches the reported class.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request, a pending request or an auto trigger
//   CAPT  | snapshot pixel_in, clear the sticky error flags
//   START | hold nn_start high for START_HOLD cycles
//   WAIT  | wait for a fresh nn_done, give up after TIMEOUT cycles
//   LATCH | store nn_class (or the invalid marker) into result
//   FAIL  | flag timeout, invalidate result
//
// Ports:
//   clk, reset (async, active-high)
//   req          : asynchronous request level, rising edge starts a run
//   auto_en      : enables periodic re-inference (only with INFER_SEQ_AUTO_EN)
//   pixel_in     : live frame; pixel_snap : frozen frame for the network
//   nn_start     : start/init to the network; nn_done / nn_class from it
//   result, result_valid, busy, timeout_err, class_err, state : status
//
// Build option: define INFER_SEQ_AUTO_EN to add the periodic auto trigger,
// which re-runs only when the live frame differs from the last snapshot.
module inference_sequencer
  import inference_seq_pkg::*;
#(
  parameter int PIXELS      = PIXELS_DEF,
  parameter int CLASS_W     = 4,
  parameter int START_HOLD  = 1000,
  parameter int TIMEOUT     = 2_000_000,
  parameter int AUTO_PERIOD = 25_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               auto_en,
  input  logic [PIXELS-1:0]  pixel_in,
  output logic [PIXELS-1:0]  pixel_snap,
  output logic               nn_start,
  input  logic               nn_done,
  input  logic [CLASS_W-1:0] nn_class,
  output logic [CLASS_W-1:0] result,
  output logic               result_valid,
  output logic               busy,
  output logic               timeout_err,
  output logic               class_err,
  output logic [2:0]         state
);

  localparam int HOLD_W = $clog2(START_HOLD + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(START_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               pending_q, pending_d;
  logic               armed_q, armed_d;
  logic               nn_start_q, nn_start_d;
  logic [PIXELS-1:0]  pixel_snap_q, pixel_snap_d;
  logic [CLASS_W-1:0] result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               timeout_err_q, timeout_err_d;
  logic               class_err_q, class_err_d;

  logic req_rise;
  logic done_lvl;
  logic unused_req_lvl;
  logic unused_done_rise;
  logic auto_trig;

  sync_edge u_req_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (req),
    .level_o (unused_req_lvl),
    .rise_o  (req_rise)
  );

  sync_edge u_done_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (nn_done),
    .level_o (done_lvl),
    .rise_o  (unused_done_rise)
  );

`ifdef INFER_SEQ_AUTO_EN
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [AUTO_W-1:0] AUTO_LOAD = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              auto_wrap;

  assign auto_wrap  = (auto_cnt_q == '0);
  assign auto_cnt_d = auto_wrap ? AUTO_LOAD : auto_cnt_q - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) auto_cnt_q <= '0;
    else       auto_cnt_q <= auto_cnt_d;
  end

  // Re-run only on a changed frame; a wrap outside IDLE is simply lost.
  assign auto_trig = auto_wrap && auto_en && (state_q == ST_IDLE) &&
                     (pixel_in != pixel_snap_q);
`else
  logic unused_auto;
  assign unused_auto = auto_en | (AUTO_PERIOD == 0);
  assign auto_trig   = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    pending_d      = pending_q;
    armed_d        = armed_q;
    nn_start_d     = 1'b0;
    pixel_snap_d   = pixel_snap_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;
    class_err_d    = class_err_q;

    // One-deep request queue; also catches an edge on the return-to-IDLE cycle.
    if (req_rise && (state_q != ST_IDLE)) pending_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (req_rise || pending_q || auto_trig) begin
          state_d   = ST_CAPTURE;
          pending_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        pixel_snap_d  = pixel_in;
        timeout_err_d = 1'b0;
        class_err_d   = 1'b0;
        hold_cnt_d    = HOLD_LOAD;
        nn_start_d    = 1'b1;
        state_d       = ST_START;
      end
      ST_START: begin
        armed_d = 1'b0;
        if (hold_cnt_q == '0) begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
          nn_start_d = 1'b1;
        end
      end
      ST_WAIT: begin
        // Only a done seen after a low level belongs to this run.
        if (!done_lvl) armed_d = 1'b1;
        if (armed_q && done_lvl) begin
          state_d = ST_LATCH;
        end else if (wait_cnt_q == '0) begin
          state_d = ST_FAIL;
        end else begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end
      end
      ST_LATCH: begin
        if (nn_class <= CLASS_W'(MAX_CLASS)) begin
          result_d       = nn_class;
          result_valid_d = 1'b1;
        end else begin
          result_d       = CLASS_W'(INVALID_CLASS);
          result_valid_d = 1'b0;
          class_err_d    = 1'b1;
        end
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        timeout_err_d  = 1'b1;
        result_valid_d = 1'b0;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      hold_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      pending_q      <= 1'b0;
      armed_q        <= 1'b0;
      nn_start_q     <= 1'b0;
      pixel_snap_q   <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      class_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      pending_q      <= pending_d;
      armed_q        <= armed_d;
      nn_start_q     <= nn_start_d;
      pixel_snap_q   <= pixel_snap_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
      class_err_q    <= class_err_d;
    end
  end

  assign pixel_snap   = pixel_snap_q;
  assign nn_start     = nn_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_err  = timeout_err_q;
  assign class_err    = class_err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_inference_sequencer.sv
module tb_inference_sequencer;

  localparam int PIX = 32;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CAPT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  logic           clk;
  logic           reset;
  logic           req;
  logic           auto_en;
  logic [PIX-1:0] pixel_in;
  logic [PIX-1:0] pixel_snap;
  logic           nn_start;
  logic           nn_done;
  logic [3:0]     nn_class;
  logic [3:0]     result;
  logic           result_valid;
  logic           busy;
  logic           timeout_err;
  logic           class_err;
  logic [2:0]     state;

  int n_cmp = 0;
  int n_err = 0;

  inference_sequencer #(
    .PIXELS      (PIX),
    .CLASS_W     (4),
    .START_HOLD  (4),
    .TIMEOUT     (50),
    .AUTO_PERIOD (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .auto_en      (auto_en),
    .pixel_in     (pixel_in),
    .pixel_snap   (pixel_snap),
    .nn_start     (nn_start),
    .nn_done      (nn_done),
    .nn_class     (nn_class),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .class_err    (class_err),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    req = 1'b1;
    step(1);
    req = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < max) begin
      if (state === s) ok = 1'b1;
      else begin
        step(1);
        i++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    n_cmp++;
    if ({nn_start, result, result_valid, busy, timeout_err, class_err, state} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_status got %b want 0",
               {nn_start, result, result_valid, busy, timeout_err, class_err, state});
    end
    n_cmp++;
    if (pixel_snap !== '0) begin
      n_err++; $display("FAIL reset_snap got %h want 0", pixel_snap);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_normal();
    int cnt;
    pixel_in = 32'hA5A5_0001;
    nn_class = 4'd7;
    pulse_req();
    step(2);
    n_cmp++;
    if (state !== S_CAPT || nn_start !== 1'b0) begin
      n_err++; $display("FAIL normal_capture state %0d start %b want 1/0", state, nn_start);
    end
    step(1);
    n_cmp++;
    if (nn_start !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL normal_latency start %b busy %b want 1/1", nn_start, busy);
    end
    cnt = 0;
    while (nn_start === 1'b1 && cnt < 20) begin
      cnt++;
      step(1);
    end
    n_cmp++;
    if (cnt != 4) begin
      n_err++; $display("FAIL normal_hold got %0d cycles want 4", cnt);
    end
    n_cmp++;
    if (pixel_snap !== 32'hA5A5_0001) begin
      n_err++; $display("FAIL normal_snap got %h want a5a50001", pixel_snap);
    end
    step(9);
    nn_done = 1'b1;
    step(3);
    n_cmp++;
    if (state !== S_LATCH || result_valid !== 1'b0) begin
      n_err++; $display("FAIL normal_done_lat state %0d valid %b want 4/0", state, result_valid);
    end
    step(1);
    n_cmp++;
    if (result !== 4'd7 || result_valid !== 1'b1 || busy !== 1'b0 || state !== S_IDLE) begin
      n_err++;
      $display("FAIL normal_result res %0d valid %b busy %b state %0d want 7/1/0/0",
               result, result_valid, busy, state);
    end
    nn_done = 1'b0;
    step(2);
  endtask

  task automatic test_stale_done();
    bit ok;
    nn_done  = 1'b1;
    nn_class = 4'd3;
    pixel_in = 32'h0000_3333;
    pulse_req();
    wait_state(S_WAIT, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL stale_reach_wait state %0d want 3", state);
    end
    step(10);
    n_cmp++;
    if (state !== S_WAIT || result !== 4'd7 || result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL stale_rejected state %0d res %0d valid %b want 3/7/1", state, result, result_valid);
    end
    nn_done = 1'b0;
    step(1);
    nn_done = 1'b1;
    step(3);
    n_cmp++;
    if (state !== S_LATCH) begin
      n_err++; $display("FAIL stale_latch state %0d want 4", state);
    end
    step(1);
    n_cmp++;
    if (result !== 4'd3 || result_valid !== 1'b1) begin
      n_err++; $display("FAIL stale_result res %0d valid %b want 3/1", result, result_valid);
    end
    nn_done = 1'b0;
    step(2);
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    pulse_req();
    wait_state(S_WAIT, 20, ok);
    cnt = 0;
    while (state === S_WAIT && cnt < 200) begin
      cnt++;
      step(1);
    end
    n_cmp++;
    if (!ok || cnt != 50 || state !== S_FAIL) begin
      n_err++; $display("FAIL timeout_len got %0d cycles state %0d want 50/5", cnt, state);
    end
    step(1);
    n_cmp++;
    if (timeout_err !== 1'b1 || result_valid !== 1'b0 || result !== 4'd3 || state !== S_IDLE) begin
      n_err++;
      $display("FAIL timeout_flags terr %b valid %b res %0d state %0d want 1/0/3/0",
               timeout_err, result_valid, result, state);
    end
    step(2);
  endtask

  task automatic test_pending();
    bit ok;
    int cnt;
    pixel_in = 32'h1111_1111;
    nn_class = 4'd5;
    pulse_req();
    wait_state(S_WAIT, 20, ok);
    n_cmp++;
    if (!ok || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL pend_clear_terr ok %b terr %b want 1/0", ok, timeout_err);
    end
    pixel_in = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      pulse_req();
      step(3);
    end
    nn_done = 1'b1;
    wait_state(S_LATCH, 10, ok);
    nn_done = 1'b0;
    step(1);
    n_cmp++;
    if (!ok || state !== S_IDLE || result !== 4'd5 || result_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pend_first ok %b state %0d res %0d valid %b want 1/0/5/1", ok, state, result, result_valid);
    end
    step(1);
    n_cmp++;
    if (state !== S_CAPT) begin
      n_err++; $display("FAIL pend_rerun state %0d want 1", state);
    end
    step(1);
    n_cmp++;
    if (pixel_snap !== 32'h2222_2222) begin
      n_err++; $display("FAIL pend_snap got %h want 22222222", pixel_snap);
    end
    wait_state(S_WAIT, 20, ok);
    pixel_in = 32'h3333_0000;
    nn_class = 4'd6;
    step(2);
    nn_done = 1'b1;
    wait_state(S_IDLE, 10, ok);
    nn_done = 1'b0;
    n_cmp++;
    if (!ok || result !== 4'd6) begin
      n_err++; $display("FAIL pend_second ok %b res %0d want 1/6", ok, result);
    end
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      step(1);
      if (busy === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 0 || pixel_snap !== 32'h2222_2222) begin
      n_err++; $display("FAIL pend_extra busy %0d cycles snap %h want 0/22222222", cnt, pixel_snap);
    end
  endtask

  task automatic test_bad_class_reset();
    bit ok;
    nn_class = 4'd12;
    pulse_req();
    wait_state(S_WAIT, 20, ok);
    step(2);
    nn_done = 1'b1;
    wait_state(S_IDLE, 10, ok);
    nn_done = 1'b0;
    n_cmp++;
    if (!ok || result !== 4'hF || result_valid !== 1'b0 || class_err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_class ok %b res %h valid %b cerr %b want 1/f/0/1", ok, result, result_valid, class_err);
    end
    step(2);
    pulse_req();
    wait_state(S_START, 20, ok);
    n_cmp++;
    if (!ok || nn_start !== 1'b1) begin
      n_err++; $display("FAIL rst_in_start ok %b start %b want 1/1", ok, nn_start);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (nn_start !== 1'b0) begin
      n_err++; $display("FAIL rst_async_start got %b want 0", nn_start);
    end
    n_cmp++;
    if ({result, result_valid, busy, timeout_err, class_err, state} !== 11'd0 || pixel_snap !== '0) begin
      n_err++;
      $display("FAIL rst_outputs res %h valid %b busy %b state %0d snap %h want all 0",
               result, result_valid, busy, state, pixel_snap);
    end
    step(2);
    reset = 1'b0;
    step(5);
    n_cmp++;
    if (busy !== 1'b0 || nn_start !== 1'b0) begin
      n_err++; $display("FAIL rst_release busy %b start %b want 0/0", busy, nn_start);
    end
  endtask

  task automatic test_auto();
    int cnt;
    auto_en  = 1'b1;
    pixel_in = 32'hCAFE_0042;
`ifdef INFER_SEQ_AUTO_EN
    begin
      bit ok;
      cnt = 0;
      while (nn_start !== 1'b1 && cnt < 104) begin
        cnt++;
        step(1);
      end
      n_cmp++;
      if (nn_start !== 1'b1) begin
        n_err++; $display("FAIL auto_start got no start within %0d cycles want start", cnt);
      end
      nn_class = 4'd2;
      wait_state(S_WAIT, 20, ok);
      step(2);
      nn_done = 1'b1;
      wait_state(S_IDLE, 10, ok);
      nn_done = 1'b0;
      n_cmp++;
      if (!ok || result !== 4'd2 || pixel_snap !== 32'hCAFE_0042) begin
        n_err++; $display("FAIL auto_result ok %b res %0d snap %h want 1/2/cafe0042", ok, result, pixel_snap);
      end
    end
`endif
    cnt = 0;
    for (int i = 0; i < 250; i++) begin
      step(1);
      if (busy === 1'b1) cnt++;
    end
    n_cmp++;
    if (cnt != 0) begin
      n_err++; $display("FAIL auto_no_rerun busy %0d cycles want 0", cnt);
    end
    auto_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req      = 1'b0;
    auto_en  = 1'b0;
    pixel_in = '0;
    nn_done  = 1'b0;
    nn_class = 4'd0;
    test_reset();
    test_normal();
    test_stale_done();
    test_timeout();
    test_pending();
    test_bad_class_reset();
    test_auto();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
